// File: rtl/shift_seq_ctrl.sv
// Sequencer for the shift_reg LED datapath: loads a seed, then issues
// a programmed number of hold/left/right/bounce steps at a divided tick.
//
// Ports:
//   i_clk, i_reset       clock, synchronous active-high reset
//   i_start, i_abort     run request (IDLE only), early stop (RUN only)
//   i_mode               00 hold, 01 left, 10 right, 11 bounce
//   i_seed, i_steps      load value and number of shift steps
//   i_sr_q               shift_reg output, drives bounce reversal
//   o_busy, o_done       LOAD/RUN flag, end-of-run pulse
//   o_sr_*               shift_reg ce/we/shift/data controls
//   o_step_count         steps issued in current/last run
module shift_seq_ctrl #(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 4096,
  parameter int CNT_W    = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [CNT_W-1:0] i_steps,
  input  logic [WIDTH-1:0] i_sr_q,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sr_ce,
  output logic             o_sr_we,
  output logic             o_sr_shift_left,
  output logic             o_sr_shift_right,
  output logic [WIDTH-1:0] o_sr_data,
  output logic [CNT_W-1:0] o_step_count
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST =
    TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nx;

  logic [1:0]       mode;
  logic [WIDTH-1:0] seed;
  logic [CNT_W-1:0] remain;
  logic [CNT_W-1:0] step_cnt;
  logic [TW-1:0]    tick;
  logic             dir_right;

  logic step;
  logic last_step;
  logic bounce_right;
  logic go_left;
  logic go_right;

  // Only the end bits of i_sr_q steer the bounce.
  logic unused_sr;
  assign unused_sr = ^i_sr_q;

  assign step = (state == S_RUN) &&
                (tick == TICK_LAST);
  assign last_step = step &&
                     (remain == CNT_W'(1));

  // Reverse when the lit bit sits at the end
  // we are heading toward; this step already
  // moves the new way.
  always_comb begin
    bounce_right = dir_right;
    if (!dir_right && i_sr_q[WIDTH-1])
      bounce_right = 1'b1;
    else if (dir_right && i_sr_q[0])
      bounce_right = 1'b0;
  end

  always_comb begin
    go_left  = 1'b0;
    go_right = 1'b0;
    unique case (1'b1)
      mode == 2'b01: go_left = 1'b1;
      mode == 2'b10: go_right = 1'b1;
      mode == 2'b11: begin
        go_left  = !bounce_right;
        go_right = bounce_right;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (i_start)
          state_nx = S_LOAD;
      S_LOAD:
        state_nx = (remain == '0) ?
                   S_DONE : S_RUN;
      S_RUN:
        if (i_abort || last_step)
          state_nx = S_DONE;
      S_DONE:
        state_nx = S_IDLE;
      default:
        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      mode      <= '0;
      seed      <= '0;
      remain    <= '0;
      step_cnt  <= '0;
      tick      <= '0;
      dir_right <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            mode      <= i_mode;
            seed      <= i_seed;
            remain    <= i_steps;
            step_cnt  <= '0;
            dir_right <= 1'b0;
          end
        end
        S_LOAD: begin
          tick <= '0;
        end
        S_RUN: begin
          tick <= step ? '0 : tick + 1'b1;
          if (step) begin
            remain   <= remain - 1'b1;
            step_cnt <= step_cnt + 1'b1;
            if (mode == 2'b11)
              dir_right <= bounce_right;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    o_busy           = 1'b0;
    o_done           = 1'b0;
    o_sr_ce          = 1'b0;
    o_sr_we          = 1'b0;
    o_sr_shift_left  = 1'b0;
    o_sr_shift_right = 1'b0;
    o_sr_data        = '0;
    case (state)
      S_LOAD: begin
        o_busy    = 1'b1;
        o_sr_ce   = 1'b1;
        o_sr_we   = 1'b1;
        o_sr_data = seed;
      end
      S_RUN: begin
        o_busy           = 1'b1;
        o_sr_ce          = step;
        o_sr_shift_left  = step && go_left;
        o_sr_shift_right = step && go_right;
      end
      S_DONE: begin
        o_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_step_count = step_cnt;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl with an attached shift_reg model.
// Expected steps are queued at start and matched as ce pulses appear.
module tb_shift_seq_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_start = 1'b0;
  logic       i_abort = 1'b0;
  logic [1:0] i_mode = '0;
  logic [7:0] i_seed = '0;
  logic [7:0] i_steps = '0;
  logic [7:0] i_sr_q;
  logic       o_busy;
  logic       o_done;
  logic       o_sr_ce;
  logic       o_sr_we;
  logic       o_sr_shift_left;
  logic       o_sr_shift_right;
  logic [7:0] o_sr_data;
  logic [7:0] o_step_count;

  always #5 i_clk = ~i_clk;

  shift_seq_ctrl #(
    .WIDTH(8),
    .TICK_DIV(4),
    .CNT_W(8)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_start(i_start),
    .i_abort(i_abort),
    .i_mode(i_mode),
    .i_seed(i_seed),
    .i_steps(i_steps),
    .i_sr_q(i_sr_q),
    .o_busy(o_busy),
    .o_done(o_done),
    .o_sr_ce(o_sr_ce),
    .o_sr_we(o_sr_we),
    .o_sr_shift_left(o_sr_shift_left),
    .o_sr_shift_right(o_sr_shift_right),
    .o_sr_data(o_sr_data),
    .o_step_count(o_step_count)
  );

  typedef struct packed {
    logic        l;
    logic        r;
    logic [15:0] off;
  } step_t;

  step_t exp_q[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int load_cyc = 0;
  logic [7:0] q = '0;

  assign i_sr_q = q;

  always @(posedge i_clk) cyc <= cyc + 1;

  // shift_reg model
  always @(posedge i_clk) begin
    if (o_sr_ce) begin
      if (o_sr_we) q <= o_sr_data;
      else if (o_sr_shift_left) q <= q << 1;
      else if (o_sr_shift_right) q <= q >> 1;
    end
  end

  // Scoreboard: each step pulse pops one expected step.
  always @(negedge i_clk) begin
    step_t e;
    logic [15:0] off;
    if (o_sr_ce && !o_sr_we) begin
      off = 16'(cyc - load_cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL step_unexpected: got ce l=%0b r=%0b at +%0d want none",
                 o_sr_shift_left, o_sr_shift_right, off);
      end else begin
        e = exp_q.pop_front();
        if ({o_sr_shift_left, o_sr_shift_right, off} !== {e.l, e.r, e.off}) begin
          errors++;
          $display("FAIL step: got l=%0b r=%0b at +%0d want l=%0b r=%0b at +%0d",
                   o_sr_shift_left, o_sr_shift_right, off, e.l, e.r, e.off);
        end
      end
    end
  end

  task automatic push(input logic l, input logic r, input int off);
    step_t e;
    e.l = l;
    e.r = r;
    e.off = 16'(off);
    exp_q.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; returns on the LOAD cycle.
  task automatic kick(input logic [1:0] m, input logic [7:0] s,
                      input logic [7:0] n);
    i_mode = m;
    i_seed = s;
    i_steps = n;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    load_cyc = cyc;
  endtask

  task automatic wait_done(output int off);
    off = -1;
    for (int i = 0; i < 64; i++) begin
      @(negedge i_clk);
      if (o_done) begin
        off = cyc - load_cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({o_busy, o_done, o_sr_ce, o_sr_we, o_sr_shift_left,
         o_sr_shift_right, o_sr_data} !== 14'h0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {o_busy, o_done, o_sr_ce,
               o_sr_we, o_sr_shift_left, o_sr_shift_right, o_sr_data});
    end
    checks++;
    if (o_step_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_count: got %0d want 0", o_step_count);
    end
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    checks++;
    if ({o_busy, o_done, o_sr_ce} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b want 000",
               {o_busy, o_done, o_sr_ce});
    end
  endtask

  task automatic test_shift_left;
    int off;
    push(1, 0, 4);
    push(1, 0, 8);
    push(1, 0, 12);
    kick(2'b01, 8'h01, 8'd3);
    checks++;
    if ({o_busy, o_sr_ce, o_sr_we, o_sr_data} !== {3'b111, 8'h01}) begin
      errors++;
      $display("FAIL left_load: got %b/%h want 111/01",
               {o_busy, o_sr_ce, o_sr_we}, o_sr_data);
    end
    wait_done(off);
    checks++;
    if (off !== 13) begin
      errors++;
      $display("FAIL left_done_at: got %0d want 13", off);
    end
    checks++;
    if (o_step_count !== 8'd3) begin
      errors++;
      $display("FAIL left_count: got %0d want 3", o_step_count);
    end
    checks++;
    if (q !== 8'h08) begin
      errors++;
      $display("FAIL left_q: got %h want 08", q);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL left_missing: got %0d left want 0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_bounce;
    int off;
    push(1, 0, 4);
    push(0, 1, 8);
    push(0, 1, 12);
    push(0, 1, 16);
    kick(2'b11, 8'h40, 8'd4);
    wait_done(off);
    checks++;
    if (off !== 17) begin
      errors++;
      $display("FAIL bounce_done_at: got %0d want 17", off);
    end
    checks++;
    if (q !== 8'h10) begin
      errors++;
      $display("FAIL bounce_q: got %h want 10", q);
    end
    checks++;
    if (o_step_count !== 8'd4) begin
      errors++;
      $display("FAIL bounce_count: got %0d want 4", o_step_count);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL bounce_missing: got %0d left want 0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_load_only;
    int off;
    kick(2'b01, 8'hA5, 8'd0);
    checks++;
    if ({o_sr_we, o_sr_data} !== {1'b1, 8'hA5}) begin
      errors++;
      $display("FAIL zero_load: got %b/%h want 1/a5", o_sr_we, o_sr_data);
    end
    wait_done(off);
    checks++;
    if (off !== 1) begin
      errors++;
      $display("FAIL zero_done_at: got %0d want 1", off);
    end
    checks++;
    if ({q, o_step_count} !== {8'hA5, 8'd0}) begin
      errors++;
      $display("FAIL zero_q_count: got %h/%0d want a5/0", q, o_step_count);
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_abort;
    push(0, 1, 4);
    push(0, 1, 8);
    kick(2'b10, 8'h80, 8'd5);
    repeat (5) @(negedge i_clk);
    i_steps = 8'd1;
    i_seed = 8'hFF;
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    repeat (2) @(negedge i_clk);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    checks++;
    if ({o_done, o_busy} !== 2'b10) begin
      errors++;
      $display("FAIL abort_done: got done/busy=%b want 10", {o_done, o_busy});
    end
    checks++;
    if (o_step_count !== 8'd2) begin
      errors++;
      $display("FAIL abort_count: got %0d want 2", o_step_count);
    end
    checks++;
    if (q !== 8'h20) begin
      errors++;
      $display("FAIL abort_q: got %h want 20", q);
    end
    repeat (4) @(negedge i_clk);
    checks++;
    if ({o_busy, q} !== {1'b0, 8'h20}) begin
      errors++;
      $display("FAIL abort_after: got busy=%b q=%h want 0/20", o_busy, q);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL abort_missing: got %0d left want 0", exp_q.size());
    end
  endtask

  task automatic test_hold;
    int off;
    push(0, 0, 4);
    push(0, 0, 8);
    kick(2'b00, 8'h3C, 8'd2);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    wait_done(off);
    checks++;
    if (off !== 9) begin
      errors++;
      $display("FAIL hold_done_at: got %0d want 9", off);
    end
    checks++;
    if ({q, o_step_count} !== {8'h3C, 8'd2}) begin
      errors++;
      $display("FAIL hold_q_count: got %h/%0d want 3c/2", q, o_step_count);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL hold_missing: got %0d left want 0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  task automatic test_reset_midrun;
    int off;
    logic seen_done;
    push(1, 0, 4);
    kick(2'b01, 8'h01, 8'd5);
    repeat (6) @(negedge i_clk);
    i_reset = 1'b1;
    @(negedge i_clk);
    checks++;
    if ({o_busy, o_done, o_sr_ce, o_sr_we, o_sr_shift_left,
         o_sr_shift_right, o_step_count} !== 14'h0) begin
      errors++;
      $display("FAIL midreset_out: got %b/%0d want 0/0",
               {o_busy, o_done, o_sr_ce, o_sr_we, o_sr_shift_left,
                o_sr_shift_right}, o_step_count);
    end
    i_reset = 1'b0;
    seen_done = 1'b0;
    repeat (6) begin
      @(negedge i_clk);
      seen_done = seen_done | o_done;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_done: got %b want 0", seen_done);
    end
    checks++;
    if (q !== 8'h02) begin
      errors++;
      $display("FAIL midreset_q: got %h want 02", q);
    end
    push(1, 0, 4);
    kick(2'b01, 8'h01, 8'd1);
    wait_done(off);
    checks++;
    if ({off, q, o_step_count} !== {32'd5, 8'h02, 8'd1}) begin
      errors++;
      $display("FAIL rerun: got +%0d q=%h n=%0d want +5 q=02 n=1",
               off, q, o_step_count);
    end
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rerun_missing: got %0d left want 0", exp_q.size());
    end
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    test_reset();
    test_shift_left();
    test_bounce();
    test_load_only();
    test_abort();
    test_hold();
    test_reset_midrun();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule
